squat_pose_animator: RTL and testbench
======================================

# squat_pose_animator

- Upstream stage of the line renderer: produces the 5-entry `line_t` stick-figure table consumed by `line_struct_gen`.
- Animates one squat repetition by interpolating every line endpoint between a standing and a squatting keyframe.
- Advances one step per video frame; updates the table only during vertical blanking, so no frame ever shows a mix of two poses.
- Counts completed repetitions for the score logic.

## Interface
Parameters:
- `STEP_LOG2`, 5 — log2 of frames per descent/ascent; `PMAX = 2**STEP_LOG2`.
- `HOLD_FRAMES`, 30 — frames held at the bottom when the hold feature is compiled in.

Ports:
- `vgaclk` in 1 — pixel clock; every flop is in this domain.
- `reset` in 1 — asynchronous, active-high.
- `vsync` in 1 — active-low vsync from `vgaController`.
- `start` in 1 — level request to begin a repetition.
- `pause` in 1 — level; freezes the animation.
- `lines` out `line_t [4:0]` — registered pose table.
- `phase` out `STEP_LOG2+1` — 0 = standing, `PMAX` = full squat.
- `state` out 2 — current `anim_state_t`.
- `rep_count` out 8 — completed repetitions; saturates at 255.
- `rep_done` out 1 — one-cycle pulse when a repetition completes.

## Operation
- Frame tick: `tick = vsync_q & ~vsync`, where `vsync_q` is a one-flop delay of `vsync`.
  - Exactly one tick per falling edge.
  - `vsync` is already synchronous to `vgaclk`; no synchroniser.
- All state, phase, hold and count changes happen only on tick cycles.
- `pause = 1` on a tick cycle: the tick is ignored in every state. `pause` wins over `start`.
- States (`anim_state_t`): STAND=0, DOWN=1, BOTTOM=2, UP=3.
  - STAND: if `start = 1`, go to DOWN with `phase <= 1`. Otherwise stay. `start` is sampled only in STAND.
  - DOWN: if `phase == PMAX`, go to BOTTOM with `hold_cnt <= 0`. Otherwise `phase + 1`.
  - BOTTOM, hold feature in: `hold_cnt + 1` per tick. At a tick with `hold_cnt == HOLD_FRAMES-1`, go to UP with `phase <= PMAX-1`.
  - BOTTOM, hold feature out: the next tick goes to UP with `phase <= PMAX-1`.
  - UP: if `phase == 1`, set `phase <= 0`, go to STAND, increment `rep_count` (saturating) and assert `rep_done` in that same cycle. Otherwise `phase - 1`.
- Interpolation, per coordinate `c`, keyframes `a` (stand) and `b` (squat):
  - `d = signed 11-bit (b - a)`.
  - `p = d * signed(phase)`, `12+STEP_LOG2` bits.
  - `c = a + (p >>> STEP_LOG2)`, truncated to 10 bits.
  - Floor rounding. Exact `a` at phase 0 and exact `b` at `PMAX`.
- Keyframe values, line 1 (body): stand (150,70)-(150,150); squat (150,102)-(150,182). All other keyframes are listed in the package.

## Timing
- Reset values:
  - `state` STAND, `phase` 0, `hold_cnt` 0.
  - `lines` = `STAND_POSE`.
  - `rep_count` 0, `rep_done` 0, `vsync_q` 1.
- `phase` and `state` update on the tick edge.
- `lines` loads from the new `phase` on the following cycle (tick+1) and holds for the whole frame. Both edges fall inside vblank (vsync starts at line 491).
- `rep_done` is high in the cycle after the completing tick edge, for exactly one cycle.
- Reset mid-animation: immediate return to all reset values. A tick pending in the reset cycle is lost.
- `vsync` held low for many cycles: a single tick. `start` toggling between ticks has no effect.

## Configuration
- `SQUAT_HOLD_EN` defined: BOTTOM dwells `HOLD_FRAMES` ticks, using a `hold_cnt` of `$clog2(HOLD_FRAMES)` bits.
  - One full repetition is 94 ticks at defaults.
- `SQUAT_HOLD_EN` undefined: no `hold_cnt`; BOTTOM lasts one tick.
  - One full repetition is 65 ticks.

## Structure
- `squat_hero_pkg` holds:
  - `line_t` (moved out of the top file);
  - `anim_state_t`;
  - the `STAND_POSE` and `SQUAT_POSE` constants (`line_t [4:0]`).
- Sub-module `lerp_coord`: combinational, inputs `a`, `b`, `phase`, output `c`. Instantiated 20 times (5 lines × 4 coordinates) via generate.
- FSM, counters and the output register stay in `squat_pose_animator`.

## Test plan
- Reset: after reset, `lines[1].y_2 = 150`, `state = STAND`, `rep_count = 0`, `rep_done = 0`.
- Half descent: hold `start = 1` for 16 vsync falling edges → `phase = 16`, `state = DOWN`, and `lines[1].y_2 = 166` one cycle after the 16th tick.
- Full repetition, hold in: tick 33 → BOTTOM; tick 63 → UP with `phase = 31`; tick 94 → STAND, `phase = 0`, `rep_done` high for one cycle, `rep_count = 1`, `lines[1].y_2 = 150`. With `SQUAT_HOLD_EN` undefined: UP at tick 34, STAND at tick 65.
- Pause: `pause = 1` for 5 ticks at `phase = 10` in DOWN → `phase`, `state` and `lines` unchanged; the next unpaused tick gives `phase = 11`.
- Vsync edge: `vsync` held low for 100 cycles → phase advances exactly once. With `start = 0` in STAND, 10 ticks → no change.
- Reset mid-UP at `phase = 20` → STAND, `phase = 0`, `lines = STAND_POSE` and `rep_count = 0` before the next clock edge.

Source files
------------

// File: rtl/squat_hero_pkg.sv
// Shared types and keyframe tables for the squat stick-figure renderer.
package squat_hero_pkg;

   localparam int unsigned COORD_W = 10;
   localparam int unsigned N_LINES = 5;

   // One stick-figure segment, endpoints (x_1,y_1)-(x_2,y_2) in screen pixels
   typedef struct packed {
      logic [COORD_W-1:0] x_1;
      logic [COORD_W-1:0] y_1;
      logic [COORD_W-1:0] x_2;
      logic [COORD_W-1:0] y_2;
   } line_t;

   typedef enum logic [1:0] {
      ANIM_STAND  = 2'd0,
      ANIM_DOWN   = 2'd1,
      ANIM_BOTTOM = 2'd2,
      ANIM_UP     = 2'd3
   } anim_state_t;

   // Lines: 0 head, 1 body, 2 arms, 3 left leg, 4 right leg (concatenated 4..0)
   localparam line_t [N_LINES-1:0] STAND_POSE = {
      line_t'{10'd150, 10'd150, 10'd170, 10'd230},
      line_t'{10'd150, 10'd150, 10'd130, 10'd230},
      line_t'{10'd120, 10'd100, 10'd180, 10'd100},
      line_t'{10'd150, 10'd70,  10'd150, 10'd150},
      line_t'{10'd150, 10'd40,  10'd150, 10'd70}
   };

   localparam line_t [N_LINES-1:0] SQUAT_POSE = {
      line_t'{10'd150, 10'd182, 10'd180, 10'd230},
      line_t'{10'd150, 10'd182, 10'd120, 10'd230},
      line_t'{10'd110, 10'd130, 10'd190, 10'd130},
      line_t'{10'd150, 10'd102, 10'd150, 10'd182},
      line_t'{10'd150, 10'd72,  10'd150, 10'd102}
   };

endpackage

// File: rtl/squat_pose_animator_lerp_coord.sv
// lerp_coord: combinational floor-rounded interpolation of one coordinate
// between keyframe a (phase 0) and keyframe b (phase 2**STEP_LOG2).
module lerp_coord
   import squat_hero_pkg::*;
#(
   parameter int unsigned STEP_LOG2 = 5
) (
   input  logic [COORD_W-1:0]   a,
   input  logic [COORD_W-1:0]   b,
   input  logic [STEP_LOG2:0]   phase,
   output logic [COORD_W-1:0]   c
);

   localparam int unsigned DW = COORD_W + 1;
   localparam int unsigned PW = 12 + STEP_LOG2;

   logic signed [DW-1:0] d;
   logic signed [PW-1:0] d_ext;
   logic signed [PW-1:0] ph_ext;
   logic signed [PW-1:0] p;
   logic signed [PW-1:0] p_sh;

   // Signed delta scaled by phase; arithmetic shift gives floor rounding
   always_comb begin
      d      = $signed(DW'(b) - DW'(a));
      d_ext  = {{(PW-DW){d[DW-1]}}, d};
      ph_ext = $signed({{(PW-STEP_LOG2-1){1'b0}}, phase});
      p      = d_ext * ph_ext;
      p_sh   = p >>> STEP_LOG2;
      c      = COORD_W'(PW'(a) + p_sh);
   end

endmodule

// File: rtl/squat_pose_animator.sv
// squat_pose_animator: steps a squat repetition once per video frame and
// publishes the interpolated pose table during vertical blanking.
// Build option: define SQUAT_HOLD_EN to dwell HOLD_FRAMES frames at the bottom.
module squat_pose_animator
   import squat_hero_pkg::*;
#(
   parameter int unsigned STEP_LOG2   = 5,
   parameter int unsigned HOLD_FRAMES = 30
) (
   input  logic                  vgaclk,
   input  logic                  reset,
   input  logic                  vsync,
   input  logic                  start,
   input  logic                  pause,
   output line_t [N_LINES-1:0]   lines,
   output logic  [STEP_LOG2:0]   phase,
   output logic  [1:0]           state,
   output logic  [7:0]           rep_count,
   output logic                  rep_done
);

   localparam int unsigned PHW  = STEP_LOG2 + 1;
   localparam logic [PHW-1:0] PMAX_V = PHW'(2**STEP_LOG2);

   localparam logic [1:0] S_STAND  = 2'(ANIM_STAND);
   localparam logic [1:0] S_DOWN   = 2'(ANIM_DOWN);
   localparam logic [1:0] S_BOTTOM = 2'(ANIM_BOTTOM);
   localparam logic [1:0] S_UP     = 2'(ANIM_UP);

`ifdef SQUAT_HOLD_EN
   localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
`endif

   logic                 vsync_q;
   logic                 tick_c;
   logic                 load_q;
   logic [1:0]           state_q, state_d;
   logic [PHW-1:0]       phase_q, phase_d;
   logic [7:0]           rep_count_q, rep_count_d;
   logic                 rep_done_q, rep_done_d;
   line_t [N_LINES-1:0]  lines_q, lines_d;

   assign tick_c = vsync_q & ~vsync;

   // Endpoint interpolators for the current phase
   for (genvar l = 0; l < N_LINES; l++) begin : g_line
      lerp_coord #(.STEP_LOG2(STEP_LOG2)) u_x1 (
         .a(STAND_POSE[l].x_1), .b(SQUAT_POSE[l].x_1), .phase(phase_q), .c(lines_d[l].x_1));
      lerp_coord #(.STEP_LOG2(STEP_LOG2)) u_y1 (
         .a(STAND_POSE[l].y_1), .b(SQUAT_POSE[l].y_1), .phase(phase_q), .c(lines_d[l].y_1));
      lerp_coord #(.STEP_LOG2(STEP_LOG2)) u_x2 (
         .a(STAND_POSE[l].x_2), .b(SQUAT_POSE[l].x_2), .phase(phase_q), .c(lines_d[l].x_2));
      lerp_coord #(.STEP_LOG2(STEP_LOG2)) u_y2 (
         .a(STAND_POSE[l].y_2), .b(SQUAT_POSE[l].y_2), .phase(phase_q), .c(lines_d[l].y_2));
   end

   // State, counters, frame-edge detect and the pose register
   always_ff @(posedge vgaclk or posedge reset) begin
      if (reset) begin
         vsync_q     <= 1'b1;
         load_q      <= 1'b0;
         state_q     <= S_STAND;
         phase_q     <= '0;
         rep_count_q <= '0;
         rep_done_q  <= 1'b0;
         lines_q     <= STAND_POSE;
`ifdef SQUAT_HOLD_EN
         hold_cnt_q  <= '0;
`endif
      end else begin
         vsync_q     <= vsync;
         load_q      <= tick_c;
         state_q     <= state_d;
         phase_q     <= phase_d;
         rep_count_q <= rep_count_d;
         rep_done_q  <= rep_done_d;
`ifdef SQUAT_HOLD_EN
         hold_cnt_q  <= hold_cnt_d;
`endif
         // Pose table refreshes once per frame, the cycle after the tick
         if (load_q) lines_q <= lines_d;
      end
   end

   // Next-state logic: one step per unpaused frame tick
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      rep_count_d = rep_count_q;
      rep_done_d  = 1'b0;
`ifdef SQUAT_HOLD_EN
      hold_cnt_d  = hold_cnt_q;
`endif
      if (tick_c && !pause) begin
         case (state_q)
            S_STAND: begin
               if (start) begin
                  state_d = S_DOWN;
                  phase_d = PHW'(1);
               end
            end
            S_DOWN: begin
               if (phase_q == PMAX_V) begin
                  state_d = S_BOTTOM;
`ifdef SQUAT_HOLD_EN
                  hold_cnt_d = '0;
`endif
               end else begin
                  phase_d = phase_q + PHW'(1);
               end
            end
            S_BOTTOM: begin
`ifdef SQUAT_HOLD_EN
               hold_cnt_d = hold_cnt_q + HW'(1);
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d = S_UP;
                  phase_d = PMAX_V - PHW'(1);
               end
`else
               state_d = S_UP;
               phase_d = PMAX_V - PHW'(1);
`endif
            end
            default: begin
               if (phase_q == PHW'(1)) begin
                  state_d    = S_STAND;
                  phase_d    = '0;
                  rep_done_d = 1'b1;
                  if (rep_count_q != 8'hFF) rep_count_d = rep_count_q + 8'd1;
               end else begin
                  phase_d = phase_q - PHW'(1);
               end
            end
         endcase
      end
   end

   assign lines     = lines_q;
   assign phase     = phase_q;
   assign state     = state_q;
   assign rep_count = rep_count_q;
   assign rep_done  = rep_done_q;

endmodule

// File: tb/tb_squat_pose_animator.sv
// Directed self-checking bench for squat_pose_animator (either hold build).
module tb_squat_pose_animator;
   import squat_hero_pkg::*;

`ifdef SQUAT_HOLD_EN
   localparam int BOTTOM_EXIT  = 63;
   localparam int REP_TICKS    = 94;
   localparam int BOTTOM_DWELL = 30;
`else
   localparam int BOTTOM_EXIT  = 34;
   localparam int REP_TICKS    = 65;
   localparam int BOTTOM_DWELL = 1;
`endif

   logic                vgaclk = 1'b0;
   logic                reset  = 1'b1;
   logic                vsync  = 1'b1;
   logic                start  = 1'b0;
   logic                pause  = 1'b0;
   line_t [N_LINES-1:0] lines;
   logic  [5:0]         phase;
   logic  [1:0]         state;
   logic  [7:0]         rep_count;
   logic                rep_done;

   int vec_cnt = 0;
   int err_cnt = 0;

   squat_pose_animator #(.STEP_LOG2(5), .HOLD_FRAMES(30)) dut (
      .vgaclk(vgaclk), .reset(reset), .vsync(vsync), .start(start), .pause(pause),
      .lines(lines), .phase(phase), .state(state), .rep_count(rep_count),
      .rep_done(rep_done));

   always #5 vgaclk = ~vgaclk;

   task automatic check_val(input string tag, input int obs, input int exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One vsync falling edge; rd counts cycles with rep_done high afterwards
   task automatic do_tick(output int rd);
      rd = 0;
      @(negedge vgaclk) vsync = 1'b0;
      repeat (3) begin
         @(negedge vgaclk);
         if (rep_done) rd++;
      end
      vsync = 1'b1;
      repeat (2) begin
         @(negedge vgaclk);
         if (rep_done) rd++;
      end
   endtask

   task automatic ticks(input int n);
      int rd;
      for (int i = 0; i < n; i++) do_tick(rd);
   endtask

   initial begin
      int rd;
      int stray;

      // Reset
      repeat (3) @(negedge vgaclk);
      reset = 1'b0;
      @(negedge vgaclk);
      check_val("rst_y2", int'(lines[1].y_2), 150);
      check_val("rst_state", int'(state), 0);
      check_val("rst_phase", int'(phase), 0);
      check_val("rst_count", int'(rep_count), 0);
      check_val("rst_done", int'(rep_done), 0);
      check_val("rst_lines", int'(lines == STAND_POSE), 1);

      // Idle ticks without start
      ticks(10);
      check_val("idle_state", int'(state), 0);
      check_val("idle_phase", int'(phase), 0);

      // Half descent
      start = 1'b1;
      ticks(16);
      start = 1'b0;
      check_val("half_phase", int'(phase), 16);
      check_val("half_state", int'(state), 1);
      check_val("half_y2", int'(lines[1].y_2), 166);
      check_val("half_arm_x1", int'(lines[2].x_1), 115);

      // Rest of the repetition
      stray = 0;
      for (int t = 17; t <= REP_TICKS; t++) begin
         do_tick(rd);
         if (t == 33) begin
            check_val("bot_state", int'(state), 2);
            check_val("bot_phase", int'(phase), 32);
            check_val("bot_y2", int'(lines[1].y_2), 182);
         end
         if (t == BOTTOM_EXIT) begin
            check_val("up_state", int'(state), 3);
            check_val("up_phase", int'(phase), 31);
            check_val("up_y2", int'(lines[1].y_2), 181);
         end
         if (t < REP_TICKS) stray += rd;
      end
      check_val("rep_state", int'(state), 0);
      check_val("rep_phase", int'(phase), 0);
      check_val("rep_pulse", rd, 1);
      check_val("rep_stray", stray, 0);
      check_val("rep_count", int'(rep_count), 1);
      check_val("rep_y2", int'(lines[1].y_2), 150);

      // Pause at phase 10
      start = 1'b1;
      ticks(1);
      start = 1'b0;
      ticks(9);
      check_val("pre_pause_phase", int'(phase), 10);
      pause = 1'b1;
      start = 1'b1;
      ticks(5);
      start = 1'b0;
      pause = 1'b0;
      check_val("pause_phase", int'(phase), 10);
      check_val("pause_state", int'(state), 1);
      check_val("pause_y2", int'(lines[1].y_2), 160);
      ticks(1);
      check_val("unpause_phase", int'(phase), 11);
      check_val("unpause_y2", int'(lines[1].y_2), 161);

      // Long vsync low gives a single step
      @(negedge vgaclk) vsync = 1'b0;
      repeat (100) @(negedge vgaclk);
      vsync = 1'b1;
      repeat (3) @(negedge vgaclk);
      check_val("vlow_phase", int'(phase), 12);

      // Drive into UP at phase 20, then reset
      ticks(20 + 1 + BOTTOM_DWELL + 11);
      check_val("mid_state", int'(state), 3);
      check_val("mid_phase", int'(phase), 20);
      check_val("mid_y2", int'(lines[1].y_2), 170);
      @(negedge vgaclk) reset = 1'b1;
      #1;
      check_val("mrst_state", int'(state), 0);
      check_val("mrst_phase", int'(phase), 0);
      check_val("mrst_lines", int'(lines == STAND_POSE), 1);
      check_val("mrst_count", int'(rep_count), 0);
      @(negedge vgaclk) reset = 1'b0;
      repeat (2) @(negedge vgaclk);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
